// File: rtl/beat_player_pkg.sv
// Shared player definitions: FSM state encoding, tempo_sel codes, tone constants
// and the period helper used by the beat clock.
package beat_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [1:0] TEMPO_NORM     = 2'b00;
  localparam logic [1:0] TEMPO_FAST     = 2'b01;
  localparam logic [1:0] TEMPO_SLOW     = 2'b10;
  localparam logic [1:0] TEMPO_NORM_ALT = 2'b11;

  // Tone frequencies (Hz) consumed by the tone lookup stage downstream.
  localparam logic [31:0] TONE_SILENCE = 32'd0;
  localparam logic [31:0] TONE_C4      = 32'd262;
  localparam logic [31:0] TONE_D4      = 32'd294;
  localparam logic [31:0] TONE_E4      = 32'd330;
  localparam logic [31:0] TONE_F4      = 32'd349;
  localparam logic [31:0] TONE_G4      = 32'd392;
  localparam logic [31:0] TONE_A4      = 32'd440;
  localparam logic [31:0] TONE_B4      = 32'd494;
  localparam logic [31:0] TONE_C5      = 32'd523;

  localparam logic [31:0] MIN_PERIOD = 32'd2;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    logic [31:0] r;
    if (p < MIN_PERIOD) begin
      r = MIN_PERIOD;
    end else begin
      r = p;
    end
    return r;
  endfunction

endpackage

// File: rtl/beat_player_tick_div.sv
// Step prescaler: counts 0..period-1 while enabled, flags the terminal count,
// holds while disabled and restarts from 0 on clear.
module tick_div
  import beat_player_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] period_i,
  input  logic        enable_i,
  input  logic        clear_i,
  output logic        tick_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // >= rather than == so a shortened period steps on the very next cycle
  assign tick_o = enable_i && (cnt_q >= (period_i - 32'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 32'd0;
    end else if (tick_o) begin
      cnt_d = 32'd0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/beat_player.sv
// Song sequencer: play/pause/stop FSM stepping the beat index at the selected
// tempo, with loop or one-shot end-of-song handling.
module beat_player
  import beat_player_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BEAT_HZ   = 8,
  parameter int unsigned LAST_BEAT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       pause,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [1:0] tempo_sel,
  output logic [7:0] ibeatNum,
  output logic       beat_tick,
  output logic       mute,
  output logic       song_done
);

  localparam logic [31:0] PERIOD_BASE = 32'(CLK_HZ / BEAT_HZ);
  localparam logic [31:0] PERIOD_NORM = clamp_period(PERIOD_BASE);
  localparam logic [31:0] PERIOD_FAST = clamp_period(PERIOD_BASE >> 1);
  localparam logic [31:0] PERIOD_SLOW = clamp_period(PERIOD_BASE << 1);
  localparam logic [7:0]  LAST_IDX    = 8'(LAST_BEAT);

  state_e      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic        tick_q, tick_d;
  logic        done_q, done_d;
  logic        mute_q, mute_d;
  logic [31:0] period_s;
  logic        div_en_s;
  logic        div_clr_s;
  logic        div_tick_s;

  always_comb begin
    period_s = PERIOD_NORM;
    case (tempo_sel)
      TEMPO_NORM:     period_s = PERIOD_NORM;
      TEMPO_FAST:     period_s = PERIOD_FAST;
      TEMPO_SLOW:     period_s = PERIOD_SLOW;
      TEMPO_NORM_ALT: period_s = PERIOD_NORM;
      default:        period_s = PERIOD_NORM;
    endcase
  end

  // Kept independent of the divider tick so the FSM has no combinational loop;
  // pause/stop freeze the prescaler in the very cycle they arrive.
  assign div_en_s  = (state_q == ST_PLAY) && !stop && !pause;
  assign div_clr_s = stop ||
                     (play && !pause && ((state_q == ST_IDLE) || (state_q == ST_DONE)));

  tick_div u_tick_div (
    .clk_i    (clk),
    .rst_i    (rst),
    .period_i (period_s),
    .enable_i (div_en_s),
    .clear_i  (div_clr_s),
    .tick_o   (div_tick_s)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
          beat_d  = 8'd0;
        end else if (pause) begin
          state_d = state_q;
        end else if (play) begin
          state_d = ST_PLAY;
          beat_d  = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_d = ST_IDLE;
          beat_d  = 8'd0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (div_tick_s) begin
          tick_d = 1'b1;
          if (beat_q == LAST_IDX) begin
            beat_d = 8'd0;
            if (loop_en) begin
              state_d = ST_PLAY;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          beat_d  = 8'd0;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (play) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = 8'd0;
      end
    endcase
  end

  assign mute_d = (state_d != ST_PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= 8'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      mute_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      mute_q  <= mute_d;
    end
  end

  assign ibeatNum  = beat_q;
  assign beat_tick = tick_q;
  assign song_done = done_q;
  assign mute      = mute_q;

endmodule

// File: tb/tb_beat_player.sv
// Scoreboard bench for beat_player with P = 4 cycles (fast 2, slow 8), LAST_BEAT = 3.
module tb_beat_player;

  logic       clk = 1'b0;
  logic       rst, play, pause, stop, loop_en;
  logic [1:0] tempo_sel;
  logic [7:0] ibeatNum;
  logic       beat_tick, mute, song_done;

  beat_player #(.CLK_HZ(16), .BEAT_HZ(4), .LAST_BEAT(3)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .tempo_sel(tempo_sel), .ibeatNum(ibeatNum),
    .beat_tick(beat_tick), .mute(mute), .song_done(song_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] beat;
    logic       done;
    logic       mute;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic exp_tick(input int c, input int b, input logic d, input logic m);
    sb_q.push_back('{cyc: c, beat: 8'(b), done: d, mute: m});
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic p, input logic pa, input logic s);
    play = p; pause = pa; stop = s;
    @(negedge clk);
    play = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  // Monitor: every beat_tick must match the oldest expected step.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missed_tick: no tick seen, expected beat %0d at cycle %0d (now %0d)",
               sb_q[0].beat, sb_q[0].cyc, cyc);
      void'(sb_q.pop_front());
    end
    if (!rst && beat_tick) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_tick: got tick with beat %0d at cycle %0d, expected none",
                 ibeatNum, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("tick_cycle", cyc, mon_e.cyc);
        check("tick_beat", ibeatNum, mon_e.beat);
        check("tick_done", song_done, mon_e.done);
        check("tick_mute", mute, mon_e.mute);
      end
    end else if (!rst && song_done) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_done: got song_done without beat_tick at cycle %0d, expected none", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0;
    loop_en = 1'b0; tempo_sel = 2'b00;
    #1 rst = 1'b1;
    #1;
    check("rst_beat", ibeatNum, 0);
    check("rst_mute", mute, 1);
    check("rst_tick", beat_tick, 0);
    check("rst_done", song_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_mute", mute, 1);

    // Looping playback at normal tempo: 0,1,2,3,0,1,2
    loop_en = 1'b1;
    t = cyc;
    for (int k = 0; k < 6; k++) exp_tick(t + 5 + 4 * k, (k + 1) % 4, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 3);
    check("play_mute", mute, 0);
    check("play_beat0", ibeatNum, 0);
    at_cycle(t + 26);
    pulse(1'b0, 1'b0, 1'b1);
    check("stop_beat", ibeatNum, 0);
    check("stop_mute", mute, 1);
    check("sb_empty_loop", sb_q.size(), 0);

    // One-shot song ends in DONE, then replay from DONE
    loop_en = 1'b0;
    repeat (3) @(negedge clk);
    t = cyc;
    exp_tick(t + 5, 1, 1'b0, 1'b0);
    exp_tick(t + 9, 2, 1'b0, 1'b0);
    exp_tick(t + 13, 3, 1'b0, 1'b0);
    exp_tick(t + 17, 0, 1'b1, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 27);
    check("done_beat", ibeatNum, 0);
    check("done_mute", mute, 1);
    check("sb_empty_done", sb_q.size(), 0);
    t = cyc;
    exp_tick(t + 5, 1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 6);
    pulse(1'b0, 1'b0, 1'b1);
    check("replay_stop_beat", ibeatNum, 0);

    // Pause with prescaler = 2, resume 2 cycles before the next step
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    t = cyc;
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 3);
    pulse(1'b0, 1'b1, 1'b0);
    check("pause_mute", mute, 1);
    at_cycle(t + 10);
    check("pause_beat", ibeatNum, 0);
    at_cycle(t + 14);
    exp_tick(t + 17, 1, 1'b0, 1'b0);
    exp_tick(t + 21, 2, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 22);
    pulse(1'b0, 1'b0, 1'b1);
    check("sb_empty_pause", sb_q.size(), 0);

    // Pause on a step cycle, then stop+pause on a step cycle
    repeat (2) @(negedge clk);
    t = cyc;
    exp_tick(t + 5, 1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 8);
    pulse(1'b0, 1'b1, 1'b0);
    at_cycle(t + 11);
    check("pause_step_beat", ibeatNum, 1);
    check("pause_step_mute", mute, 1);
    at_cycle(t + 12);
    exp_tick(t + 14, 2, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 17);
    pulse(1'b0, 1'b1, 1'b1);
    at_cycle(t + 19);
    check("stoppause_beat", ibeatNum, 0);
    check("stoppause_mute", mute, 1);
    check("stoppause_tick", beat_tick, 0);
    repeat (4) @(negedge clk);
    check("sb_empty_stoppause", sb_q.size(), 0);

    // Slow -> fast switch at prescaler = 5, then async reset mid-song
    tempo_sel = 2'b10;
    t = cyc;
    pulse(1'b1, 1'b0, 1'b0);
    at_cycle(t + 6);
    exp_tick(t + 7, 1, 1'b0, 1'b0);
    exp_tick(t + 9, 2, 1'b0, 1'b0);
    exp_tick(t + 11, 3, 1'b0, 1'b0);
    tempo_sel = 2'b01;
    at_cycle(t + 11);
    #1 rst = 1'b1;
    #1;
    check("arst_beat", ibeatNum, 0);
    check("arst_tick", beat_tick, 0);
    check("arst_mute", mute, 1);
    check("arst_done", song_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tempo_sel = 2'b00;
    t = cyc;
    at_cycle(t + 10);
    check("post_rst_beat", ibeatNum, 0);
    check("post_rst_mute", mute, 1);
    check("sb_empty_end", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/beat_player.md
BEAT_PLAYER -- requirements
Module: beat_player

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, SHALL be the system clock frequency in Hz.
REQ-002 Parameter BEAT_HZ, default 8, SHALL be the nominal rate of quarter-beat steps in Hz.
REQ-003 Parameter LAST_BEAT, default 255, SHALL be the final beat index of the song table.
REQ-004 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 play  input  1  SHALL be a one-cycle request to start or resume playback.
REQ-007 pause  input  1  SHALL be a one-cycle request to freeze playback.
REQ-008 stop  input  1  SHALL be a one-cycle request to abort playback and rewind.
REQ-009 loop_en  input  1  SHALL be a level; when high, the song restarts after LAST_BEAT.
REQ-010 tempo_sel  input  2  SHALL select the step period: 00 = P, 01 = P/2 (fast), 10 = 2P (slow), 11 = P, with P = CLK_HZ/BEAT_HZ.
REQ-011 ibeatNum  output  8  SHALL be the current beat index that drives the tone lookup stage.
REQ-012 beat_tick  output  1  SHALL be a one-cycle pulse in the cycle ibeatNum advances.
REQ-013 mute  output  1  SHALL be high whenever the state is not PLAY.
REQ-014 song_done  output  1  SHALL be a one-cycle pulse when a non-looping song finishes.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY, PAUSE and DONE.
REQ-016 Command priority SHALL be stop > pause > play when several commands are asserted in one cycle.
REQ-017 IDLE + play SHALL enter PLAY with ibeatNum = 0 and the prescaler = 0.
REQ-018 In PLAY, a 32-bit prescaler SHALL count 0..period-1; at period-1 it SHALL wrap to 0, ibeatNum SHALL increment and beat_tick SHALL pulse in that cycle.
REQ-019 In PLAY, on a step while ibeatNum == LAST_BEAT with loop_en = 1, ibeatNum SHALL become 0 and the FSM SHALL stay in PLAY.
REQ-020 In PLAY, on a step while ibeatNum == LAST_BEAT with loop_en = 0, the FSM SHALL enter DONE, ibeatNum SHALL become 0, and song_done and beat_tick SHALL pulse in the same cycle.
REQ-021 PLAY + pause SHALL enter PAUSE, holding both ibeatNum and the prescaler; no beat_tick is issued in that cycle even if the prescaler is at period-1.
REQ-022 PAUSE + play SHALL return to PLAY, resuming from the held prescaler value.
REQ-023 stop in any state SHALL enter IDLE with ibeatNum = 0 and the prescaler = 0; stop beats a coincident step.
REQ-024 DONE + play SHALL enter PLAY from beat 0; pause in IDLE or DONE SHALL be ignored; play in PLAY SHALL be ignored.
REQ-025 A tempo_sel change SHALL take effect immediately; if the prescaler is ≥ new period-1, the step SHALL occur on the next cycle.
REQ-026 The period SHALL be computed at elaboration as 32-bit constants, each with a minimum of 2 cycles.

Reset
REQ-027 rst SHALL force state = IDLE, ibeatNum = 0, prescaler = 0, beat_tick = 0, song_done = 0 and mute = 1, independent of clk.
REQ-028 Reset asserted mid-song SHALL discard all playback position; after release, only play restarts playback.

Structure
REQ-029 The state encoding and the tempo_sel codes SHALL live in the shared player package with the tone constants.
REQ-030 The prescaler SHALL be one sub-module, tick_div (inputs: period, enable, clear; output: tick), and the FSM and beat counter SHALL live in beat_player.

Verification
REQ-031 With CLK_HZ = 16, BEAT_HZ = 4 (P = 4), tempo 00: play -> beat_tick every 4 cycles; ibeatNum 0,1,2,3...; mute = 0.
REQ-032 LAST_BEAT = 3, loop_en = 0: play -> after 16 cycles, song_done pulses once, ibeatNum = 0, mute = 1, state DONE.
REQ-033 LAST_BEAT = 3, loop_en = 1: the sequence 0,1,2,3,0,1 continues with no song_done.
REQ-034 pause at prescaler = 2, wait 10 cycles, then play -> next tick comes exactly 2 cycles later; ibeatNum is unchanged during the pause.
REQ-035 stop and pause in the same cycle as a step -> no beat_tick, state IDLE, ibeatNum = 0.
REQ-036 tempo 10 -> 01 switch with prescaler = 5 -> tick on the next cycle; later ticks every 2 cycles. rst pulse mid-song -> all outputs at reset values asynchronously.
